irrigation_sequencer: RTL and testbench

IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

---
 rtl/irrigation_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// ---------------------------------------------------------------------------
// irrigation_sequencer
//
// Purpose: times one irrigation cycle. A request loads a 15:00 (sprinkler)
// or 30:00 (dripper) countdown. The valve opens while the countdown runs,
// and the count drops by 10 s on every tick_10s. A normal completion pulses
// done. A sensor conflict, or a dropped request, aborts the cycle at once.
//
// Ports:
//   clock               in   rising-edge clock for all state
//   reset               in   synchronous, active-high reset
//   tick_10s            in   one-cycle pulse every 10 s
//   irrigation_request  in   level, demand for water
//   splinker_mode_on    in   1 = sprinkler 15:00, 0 = dripper 30:00 (sampled in LOAD)
//   conflicting_values  in   level, sensor fault, highest-priority abort
//   pause_button        in   level, hold to pause the countdown
//   minutes_d           out  tens-of-minutes BCD digit
//   minutes_u           out  units-of-minutes BCD digit
//   seconds_d           out  tens-of-seconds BCD digit
//   valve_on            out  irrigation valve drive
//   done                out  one-cycle pulse on normal completion
//   state               out  current FSM encoding
//
// Configuration: define IRRIGATION_SEQUENCER_PAUSE_EN to enable the PAUSE
// state. When it is undefined, pause_button is ignored, and encoding 011
// falls back to IDLE like any other unused encoding.
// ---------------------------------------------------------------------------
module irrigation_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_10s,
    input  logic       irrigation_request,
    input  logic       splinker_mode_on,
    input  logic       conflicting_values,
    input  logic       pause_button,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic       valve_on,
    output logic       done,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_RUN   = 3'b010;
`ifdef IRRIGATION_SEQUENCER_PAUSE_EN
    localparam logic [2:0] S_PAUSE = 3'b011;
`endif
    localparam logic [2:0] S_DONE  = 3'b100;

    logic [2:0] state_q, state_d;
    logic [1:0] md_q, md_d;
    logic [3:0] mu_q, mu_d;
    logic [2:0] sd_q, sd_d;
    logic       valve_q, valve_d;
    logic       done_q, done_d;

    logic       abort;
    logic       pause_req;
    logic       count_zero;
    logic [8:0] dec_count;

`ifdef IRRIGATION_SEQUENCER_PAUSE_EN
    assign pause_req = pause_button;
`else
    logic unused_pause;
    assign unused_pause = pause_button;
    assign pause_req    = 1'b0;
`endif

    // Subtract 10 s from an M M : S0 BCD count. The seconds digit wraps 0->5
    // and the minutes-units digit wraps 0->9, each one borrowing from the
    // next digit up. Callers never pass 00:00.
    function automatic logic [8:0] dec10(input logic [1:0] md,
                                         input logic [3:0] mu,
                                         input logic [2:0] sd);
        logic [1:0] n_md;
        logic [3:0] n_mu;
        logic [2:0] n_sd;
        n_md = md;
        n_mu = mu;
        n_sd = sd;
        if (sd != 3'd0) begin
            n_sd = sd - 3'd1;
        end else begin
            n_sd = 3'd5;
            if (mu != 4'd0) begin
                n_mu = mu - 4'd1;
            end else begin
                n_mu = 4'd9;
                n_md = md - 2'd1;
            end
        end
        return {n_md, n_mu, n_sd};
    endfunction

    assign abort      = conflicting_values | ~irrigation_request;
    assign count_zero = (md_q == 2'd0) && (mu_q == 4'd0) && (sd_q == 3'd0);
    assign dec_count  = dec10(md_q, mu_q, sd_q);

    always_comb begin
        state_d = state_q;
        md_d    = md_q;
        mu_d    = mu_q;
        sd_d    = sd_q;

        case (state_q)
            S_IDLE: begin
                md_d = 2'd0;
                mu_d = 4'd0;
                sd_d = 3'd0;
                if (irrigation_request && !conflicting_values) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // The mode is sampled only here, so later changes wait for
                // the next load.
                if (splinker_mode_on) begin
                    md_d = 2'd1;
                    mu_d = 4'd5;
                end else begin
                    md_d = 2'd3;
                    mu_d = 4'd0;
                end
                sd_d    = 3'd0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // An abort or a pause consumes a coincident tick. Zero is
                // checked before the tick, so the count can never wrap
                // below 00:00.
                if (abort) begin
                    state_d = S_IDLE;
                    md_d    = 2'd0;
                    mu_d    = 4'd0;
                    sd_d    = 3'd0;
                end else if (pause_req) begin
`ifdef IRRIGATION_SEQUENCER_PAUSE_EN
                    state_d = S_PAUSE;
`endif
                end else if (count_zero) begin
                    state_d = S_DONE;
                end else if (tick_10s) begin
                    {md_d, mu_d, sd_d} = dec_count;
                end
            end

`ifdef IRRIGATION_SEQUENCER_PAUSE_EN
            S_PAUSE: begin
                // The count is frozen and ticks are dropped.
                if (abort) begin
                    state_d = S_IDLE;
                    md_d    = 2'd0;
                    mu_d    = 4'd0;
                    sd_d    = 3'd0;
                end else if (!pause_button) begin
                    state_d = S_RUN;
                end
            end
`endif

            S_DONE: begin
                // Stay here until the request drops, so that a persistent
                // request does not start a new cycle.
                md_d = 2'd0;
                mu_d = 4'd0;
                sd_d = 3'd0;
                if (!irrigation_request) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                md_d    = 2'd0;
                mu_d    = 4'd0;
                sd_d    = 3'd0;
            end
        endcase

        // The outputs are registered from the next state, so they line up
        // with the state register.
        valve_d = (state_d == S_RUN);
        done_d  = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            md_q    <= 2'd0;
            mu_q    <= 4'd0;
            sd_q    <= 3'd0;
            valve_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            md_q    <= md_d;
            mu_q    <= mu_d;
            sd_q    <= sd_d;
            valve_q <= valve_d;
            done_q  <= done_d;
        end
    end

    assign state     = state_q;
    assign minutes_d = md_q;
    assign minutes_u = mu_q;
    assign seconds_d = sd_q;
    assign valve_on  = valve_q;
    assign done      = done_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
module tb_irrigation_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_10s;
    logic       irrigation_request;
    logic       splinker_mode_on;
    logic       conflicting_values;
    logic       pause_button;
    logic [1:0] minutes_d;
    logic [3:0] minutes_u;
    logic [2:0] seconds_d;
    logic       valve_on;
    logic       done;
    logic [2:0] state;

    irrigation_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .tick_10s           (tick_10s),
        .irrigation_request (irrigation_request),
        .splinker_mode_on   (splinker_mode_on),
        .conflicting_values (conflicting_values),
        .pause_button       (pause_button),
        .minutes_d          (minutes_d),
        .minutes_u          (minutes_u),
        .seconds_d          (seconds_d),
        .valve_on           (valve_on),
        .done               (done),
        .state              (state)
    );

    always #5 clock = ~clock;

`ifdef IRRIGATION_SEQUENCER_PAUSE_EN
    localparam bit M_PAUSE = 1'b1;
`else
    localparam bit M_PAUSE = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model. The remaining time is held in plain seconds, and the
    // phase is held as the externally visible state code.
    int m_st  = 0;
    int m_rem = 0;
    bit m_valve = 1'b0;
    bit m_done  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] digits_of(input int rem);
        int md, mu, sd;
        md = rem / 600;
        mu = (rem / 60) % 10;
        sd = (rem % 60) / 10;
        return {md[1:0], mu[3:0], sd[2:0]};
    endfunction

    task automatic model_edge();
        int ost;
        ost = m_st;
        if (reset) begin
            m_st = 0; m_rem = 0; m_valve = 1'b0; m_done = 1'b0;
            return;
        end
        case (ost)
            0: begin
                m_rem = 0;
                if (irrigation_request && !conflicting_values) m_st = 1;
            end
            1: begin
                m_rem = splinker_mode_on ? 900 : 1800;
                m_st  = 2;
            end
            2, 3: begin
                if (conflicting_values || !irrigation_request) begin
                    m_st = 0; m_rem = 0;
                end else if (M_PAUSE && pause_button) begin
                    m_st = 3;
                end else if (ost == 3) begin
                    m_st = 2;
                end else if (m_rem == 0) begin
                    m_st = 4;
                end else if (tick_10s) begin
                    m_rem = m_rem - 10;
                end
            end
            4: begin
                m_rem = 0;
                if (!irrigation_request) m_st = 0;
            end
            default: begin
                m_st = 0; m_rem = 0;
            end
        endcase
        m_valve = (m_st == 2);
        m_done  = (m_st == 4) && (ost != 4);
    endtask

    // One clock edge. The task applies the model, samples 1 ns after the
    // edge, compares the whole output word, then waits for the next falling
    // edge so that the caller can drive new inputs.
    task automatic step(input string tag);
        logic [2:0]  st3;
        logic [13:0] exp;
        @(posedge clock);
        model_edge();
        #1;
        st3 = m_st[2:0];
        exp = {st3, digits_of(m_rem), m_valve, m_done};
        chk(tag, {18'd0, state, minutes_d, minutes_u, seconds_d, valve_on, done},
                 {18'd0, exp});
        @(negedge clock);
    endtask

    task automatic chk_digits(input string tag, input int md, input int mu, input int sd);
        chk(tag, {23'd0, minutes_d, minutes_u, seconds_d},
                 {23'd0, md[1:0], mu[3:0], sd[2:0]});
    endtask

    initial begin
        reset = 1'b1; tick_10s = 1'b0; irrigation_request = 1'b0;
        splinker_mode_on = 1'b0; conflicting_values = 1'b0; pause_button = 1'b0;
        @(negedge clock);

        // Reset state: requests and ticks are overridden.
        irrigation_request = 1'b1; tick_10s = 1'b1;
        step("reset");
        chk("reset_state", {29'd0, state}, 32'd0);
        chk_digits("reset_digits", 0, 0, 0);
        chk("reset_valve", {31'd0, valve_on}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);

        // Sprinkler run.
        reset = 1'b0; tick_10s = 1'b0; splinker_mode_on = 1'b1;
        step("to_load");
        chk("load_state", {29'd0, state}, 32'd1);
        chk("load_valve", {31'd0, valve_on}, 32'd0);
        step("to_run");
        splinker_mode_on = 1'b0;   // mode change after LOAD has no effect
        chk("spr_state", {29'd0, state}, 32'd2);
        chk_digits("spr_load", 1, 5, 0);
        chk("spr_valve", {31'd0, valve_on}, 32'd1);
        tick_10s = 1'b1;
        for (int i = 0; i < 90; i++) step("spr_tick");
        chk_digits("spr_zero", 0, 0, 0);
        chk("spr_zero_state", {29'd0, state}, 32'd2);
        tick_10s = 1'b0;
        step("to_done");
        chk("done_state", {29'd0, state}, 32'd4);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valve", {31'd0, valve_on}, 32'd0);
        step("done_hold");
        chk("done_once", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) step("done_hold");
        chk("done_stays", {29'd0, state}, 32'd4);
        chk_digits("done_noreload", 0, 0, 0);
        irrigation_request = 1'b0;
        step("done_exit");
        chk("idle_again", {29'd0, state}, 32'd0);

        // Dripper borrows.
        irrigation_request = 1'b1; splinker_mode_on = 1'b0;
        step("drip_load");
        step("drip_run");
        chk_digits("drip_load", 3, 0, 0);
        tick_10s = 1'b1;
        step("drip_tick");
        chk_digits("drip_borrow", 2, 9, 5);
        for (int i = 0; i < 19; i++) step("drip_tick");
        chk_digits("drip_20", 2, 6, 4);

        // Abort at 12:30 with a coincident tick.
        for (int i = 0; i < 200 && m_rem != 750; i++) step("drip_tick");
        chk_digits("at_1_2_3", 1, 2, 3);
        conflicting_values = 1'b1;
        step("abort");
        chk("abort_state", {29'd0, state}, 32'd0);
        chk_digits("abort_digits", 0, 0, 0);
        chk("abort_valve", {31'd0, valve_on}, 32'd0);
        conflicting_values = 1'b0; tick_10s = 1'b0;

        // Pause at 05:00.
        splinker_mode_on = 1'b1;
        step("p_load");
        step("p_run");
        tick_10s = 1'b1;
        for (int i = 0; i < 200 && m_rem != 300; i++) step("p_tick");
        chk_digits("at_0_5_0", 0, 5, 0);
        pause_button = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_10s = (i == 1 || i == 3);
            step("pause_hold");
        end
`ifdef IRRIGATION_SEQUENCER_PAUSE_EN
        chk_digits("pause_frozen", 0, 5, 0);
        chk("pause_valve", {31'd0, valve_on}, 32'd0);
        chk("pause_state", {29'd0, state}, 32'd3);
`else
        chk_digits("pause_ignored", 0, 4, 4);
        chk("pause_valve", {31'd0, valve_on}, 32'd1);
        chk("pause_state", {29'd0, state}, 32'd2);
`endif
        pause_button = 1'b0; tick_10s = 1'b0;
        step("pause_release");
        chk("resume_state", {29'd0, state}, 32'd2);
        chk("resume_valve", {31'd0, valve_on}, 32'd1);

        // Reset in the middle of RUN.
        reset = 1'b1; tick_10s = 1'b1;
        step("mid_reset");
        chk("mid_reset_state", {29'd0, state}, 32'd0);
        chk_digits("mid_reset_digits", 0, 0, 0);
        chk("mid_reset_valve", {31'd0, valve_on}, 32'd0);
        reset = 1'b0; tick_10s = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            reset              = ($urandom_range(0, 1999) == 0);
            tick_10s           = ($urandom_range(0, 1) == 0);
            splinker_mode_on   = $urandom_range(0, 1) != 0;
            conflicting_values = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 299) == 0) irrigation_request = ~irrigation_request;
            if ($urandom_range(0, 49) == 0)  pause_button = ~pause_button;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
